// File: rtl/dot_pkg.sv
// Shared definitions for the serial 3-element dot-product datapath.
// Contents: element width, vector length, result width and the result type.
package dot_pkg;

  localparam int DOT_ELEM_W = 8;
  localparam int DOT_LEN    = 3;
  // 3 x 255 x 255 = 195075 fits in 18 bits.
  localparam int DOT_W      = 18;

  typedef logic [DOT_W-1:0] dot_res_t;

endpackage

// File: rtl/dot_sync_fifo.sv
// Synchronous FIFO that holds dot-product results.
// Ports:
//   clk, resetn       clock, asynchronous active-low reset
//   wr_data, wr_req   write word and write request (no backpressure upstream)
//   push              write request was accepted this cycle
//   rd_data, rd_valid head word (forced to 0 when empty) and its valid flag
//   rd_ready          consumer takes the head word this cycle
//   level             occupancy, 0..DEPTH
// A full FIFO still accepts a write in a cycle where the head is popped.
module dot_sync_fifo
  import dot_pkg::*;
#(
  parameter int DW    = DOT_W,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [DW-1:0]          wr_data,
  input  logic                   wr_req,
  output logic                   push,
  output logic [DW-1:0]          rd_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   level_nxt;
  logic          pop;

  assign pop  = rd_valid && rd_ready;
  assign push = wr_req && ((level != FULL_LVL) || pop);

  always_comb begin
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + 1'b1;
      2'b01:   level_nxt = level - 1'b1;
      default: level_nxt = level;
    endcase
  end

  // Control state: pointers, occupancy and the registered valid flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level    <= level_nxt;
      rd_valid <= (level_nxt != '0);
    end
  end

  // Storage is data only and carries no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Gating by rd_valid makes the output read 0 the moment reset asserts.
  assign rd_data = rd_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/dot_result_buffer.sv
// Result buffer behind the serial dot-product unit.
// Captures each result on the unit's one-cycle strobe, buffers it and
// presents it on a valid/ready interface; counts results lost to a full
// buffer.
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   in_data, in_valid    result word and its one-cycle strobe
//   out_data, out_valid  head result (0 when not valid) and valid flag
//   out_ready            consumer accepts out_data this cycle
//   level                occupancy, 0..DEPTH
//   overflow             sticky flag, set when a result was dropped
//   drop_cnt             saturating count of dropped results
//   clr_stats            synchronous clear of overflow/drop_cnt (and max)
// Optional (macro DOT_RESULT_MAX_EN):
//   max_val              largest accepted result since reset/clear
//   max_upd              one-cycle pulse when max_val takes a new value
module dot_result_buffer
  import dot_pkg::*;
#(
  parameter int DW    = DOT_W,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [DW-1:0]          in_data,
  input  logic                   in_valid,
  output logic [DW-1:0]          out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_cnt,
  input  logic                   clr_stats
`ifdef DOT_RESULT_MAX_EN
  ,
  output logic [DW-1:0]          max_val,
  output logic                   max_upd
`endif
);

  logic push;
  logic drop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  dot_sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .wr_data  (in_data),
    .wr_req   (in_valid),
    .push     (push),
    .rd_data  (out_data),
    .rd_valid (out_valid),
    .rd_ready (out_ready),
    .level    (level)
  );

  // A strobe the FIFO refuses is exactly a full buffer without a pop.
  assign drop = in_valid && !push;

  // Statistics: a drop coinciding with a clear counts as the first drop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      drop_cnt <= clr_stats ? CNT_W'(1) : sat_inc(drop_cnt);
    end else if (clr_stats) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

`ifdef DOT_RESULT_MAX_EN
  logic [DW-1:0] max_base;

  // A clear in the same cycle compares the new word against zero.
  assign max_base = clr_stats ? '0 : max_val;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      max_val <= '0;
      max_upd <= 1'b0;
    end else begin
      max_upd <= 1'b0;
      if (push && (in_data > max_base)) begin
        max_val <= in_data;
        max_upd <= 1'b1;
      end else if (clr_stats) begin
        max_val <= '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dot_result_buffer.sv
// Directed self-checking bench for dot_result_buffer.
// Inputs change 1 ns after the rising edge; outputs are checked there too.
// The max-tracker section is compiled only with DOT_RESULT_MAX_EN.
module tb_dot_result_buffer;
  import dot_pkg::*;

  localparam int DW    = DOT_W;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic                   clk;
  logic                   resetn;
  dot_res_t               in_data;
  logic                   in_valid;
  dot_res_t               out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [$clog2(DEPTH):0] level;
  logic                   overflow;
  logic [CNT_W-1:0]       drop_cnt;
  logic                   clr_stats;
`ifdef DOT_RESULT_MAX_EN
  dot_res_t               max_val;
  logic                   max_upd;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  dot_result_buffer #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
    .clr_stats (clr_stats)
`ifdef DOT_RESULT_MAX_EN
    ,
    .max_val   (max_val),
    .max_upd   (max_upd)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int v);
    in_data  = DW'(v);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    resetn    = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr_stats = 1'b0;
    #12;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    resetn = 1'b1;
    tick();

    // 1: single result 1*4+2*5+3*6 = 32, consumer ready
    out_ready = 1'b1;
    strobe(32);
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_data", 32'(out_data), 32);
    chk("t1_level", 32'(level), 1);
    tick();
    chk("t1_empty_valid", 32'(out_valid), 0);
    chk("t1_empty_level", 32'(level), 0);
    chk("t1_empty_data", 32'(out_data), 0);

    // 2: fill while stalled, then drain in order
    out_ready = 1'b0;
    strobe(10); strobe(20); strobe(30); strobe(40);
    chk("t2_level", 32'(level), 4);
    chk("t2_valid", 32'(out_valid), 1);
    chk("t2_head", 32'(out_data), 10);
    tick();
    chk("t2_hold", 32'(out_data), 10);
    chk("t2_hold_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    tick(); chk("t2_pop1", 32'(out_data), 20);
    tick(); chk("t2_pop2", 32'(out_data), 30);
    tick(); chk("t2_pop3", 32'(out_data), 40);
    chk("t2_lvl1", 32'(level), 1);
    tick();
    chk("t2_end_valid", 32'(out_valid), 0);
    chk("t2_end_level", 32'(level), 0);

    // 3: drop on full, clear, drop-with-clear
    out_ready = 1'b0;
    strobe(1); strobe(2); strobe(3); strobe(4);
    strobe(99);
    chk("t3_ovf", 32'(overflow), 1);
    chk("t3_drop", 32'(drop_cnt), 1);
    chk("t3_level", 32'(level), 4);
    chk("t3_head", 32'(out_data), 1);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    chk("t3_clr_ovf", 32'(overflow), 0);
    chk("t3_clr_drop", 32'(drop_cnt), 0);
    chk("t3_clr_level", 32'(level), 4);
    strobe(98);
    strobe(97);
    chk("t3_drop2", 32'(drop_cnt), 2);
    clr_stats = 1'b1;
    strobe(77);
    chk("t3_dclr_ovf", 32'(overflow), 1);
    chk("t3_dclr_drop", 32'(drop_cnt), 1);
    tick();
    clr_stats = 1'b0;
    chk("t3_clr2_drop", 32'(drop_cnt), 0);

    // 4: full with pop and push together accepts the word
    out_ready = 1'b1;
    strobe(195075);
    chk("t4_level", 32'(level), 4);
    chk("t4_drop", 32'(drop_cnt), 0);
    chk("t4_ovf", 32'(overflow), 0);
    chk("t4_head", 32'(out_data), 2);
    tick(); chk("t4_pop2", 32'(out_data), 3);
    tick(); chk("t4_pop3", 32'(out_data), 4);
    tick(); chk("t4_pop4", 32'(out_data), 195075);
    tick();
    chk("t4_end_level", 32'(level), 0);
    chk("t4_end_valid", 32'(out_valid), 0);

    // 5: asynchronous reset with three entries buffered
    out_ready = 1'b0;
    strobe(7); strobe(8); strobe(9); strobe(6);
    strobe(5);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t5_pre_level", 32'(level), 3);
    chk("t5_pre_drop", 32'(drop_cnt), 1);
    chk("t5_pre_head", 32'(out_data), 8);
    #2;
    resetn = 1'b0;
    #1;
    chk("t5_valid", 32'(out_valid), 0);
    chk("t5_level", 32'(level), 0);
    chk("t5_data", 32'(out_data), 0);
    chk("t5_drop", 32'(drop_cnt), 0);
    chk("t5_ovf", 32'(overflow), 0);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    chk("t5_after_level", 32'(level), 0);
    chk("t5_after_valid", 32'(out_valid), 0);

`ifdef DOT_RESULT_MAX_EN
    // 6: running maximum of accepted results
    out_ready = 1'b1;
    chk("t6_rst_max", 32'(max_val), 0);
    strobe(5);
    chk("t6_upd5", 32'(max_upd), 1);
    chk("t6_max5", 32'(max_val), 5);
    strobe(100);
    chk("t6_upd100", 32'(max_upd), 1);
    chk("t6_max100", 32'(max_val), 100);
    strobe(50);
    chk("t6_upd50", 32'(max_upd), 0);
    chk("t6_max50", 32'(max_val), 100);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    chk("t6_clr_max", 32'(max_val), 0);
    chk("t6_clr_upd", 32'(max_upd), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
